beat_note_scheduler: RTL and testbench
======================================

BEAT_NOTE_SCHEDULER -- requirements
Module: beat_note_scheduler

Interface
REQ-001 Parameter BEAT_DIV, default 12500000; clock cycles per beat, legal range >=2.
REQ-002 Parameter DEPTH, default 8; note FIFO depth, power of two, >=2.
REQ-003 Parameter BASE, default 40; note code of lane 0.
REQ-004 Parameter STEP, default 4; code increment between adjacent lanes.
REQ-005 Parameter LANES, default 5; number of valid lanes, <=7.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 resetn  input  1  reset, asynchronous, active-low.
REQ-008 clear  input  1  synchronous flush of FIFO, output, beat counter and overflow.
REQ-009 in_en  input  1  in_data valid this cycle; no backpressure to producer.
REQ-010 in_data  input  8  incoming note code from the beatmap generator.
REQ-011 note_valid  output  1  note_code/note_lane/note_bad hold a note.
REQ-012 note_ready  input  1  consumer accepts the held note when high with note_valid.
REQ-013 note_code  output  8  held note code.
REQ-014 note_lane  output  3  lane index of held note; 7 when invalid.
REQ-015 note_bad  output  1  held code is off-grid or out of lane range.
REQ-016 beat  output  1  one-cycle pulse per beat period.
REQ-017 miss  output  1  one-cycle pulse on a beat that released no note.
REQ-018 fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-019 overflow  output  1  sticky: an input note was dropped.

Function
REQ-020 Beat counter SHALL count 0..BEAT_DIV-1 and wrap to 0; beat SHALL be high exactly in the cycle the counter equals BEAT_DIV-1.
REQ-021 First beat after reset or clear SHALL occur BEAT_DIV cycles later (counter restarts at 0).
REQ-022 A push SHALL occur when in_en=1 and (FIFO not full, or a pop occurs in the same cycle).
REQ-023 When in_en=1 with FIFO full and no same-cycle pop, the note SHALL be dropped and overflow SHALL set and remain set until reset or clear.
REQ-024 A pop SHALL occur only when beat=1, FIFO non-empty and (note_valid=0 or note_ready=1); the popped entry SHALL load the output register on the same edge (one-cycle latency from beat to note_valid).
REQ-025 Simultaneous push and pop SHALL leave fifo_count unchanged; a push into an empty FIFO SHALL NOT be poppable in the same cycle.
REQ-026 note_valid SHALL set on a pop, clear on note_valid&note_ready without a pop, and stay set with stable outputs otherwise.
REQ-027 At most one note SHALL be released per beat; notes SHALL be released in arrival order.
REQ-028 miss SHALL pulse in the beat cycle when no pop occurs (FIFO empty or output held and note_ready=0); FIFO contents SHALL be unaffected.
REQ-029 Lane: if in_data>=BASE, (in_data-BASE) mod STEP=0 and (in_data-BASE)/STEP<LANES, note_lane=(in_data-BASE)/STEP and note_bad=0; else note_lane=7, note_bad=1; computed at pop from stored code.
REQ-030 Arithmetic SHALL be unsigned 8-bit without wrap (codes below BASE are bad, not wrapped).
REQ-031 clear SHALL take priority over push, pop and beat in its cycle: FIFO emptied, note_valid=0, counter=0, overflow=0, beat=0, miss=0.
REQ-032 fifo_count SHALL equal pushes minus pops since last reset/clear, within 0..DEPTH.

Reset
REQ-033 resetn low SHALL asynchronously force: note_valid=0, note_code=0, note_lane=0, note_bad=0, beat=0, miss=0, fifo_count=0, overflow=0, beat counter=0, FIFO pointers=0.
REQ-034 Reset asserted mid-operation SHALL discard all queued and held notes; no stale note SHALL appear after release.
REQ-035 After resetn deasserts, the first beat SHALL occur at the BEAT_DIV-th rising edge.

Verification (BEAT_DIV=4, DEPTH=8, defaults otherwise)
REQ-036 Push 40,44,48,52,56 on consecutive cycles, note_ready=1 -> released one per beat in order, lanes 0,1,2,3,4, note_bad=0.
REQ-037 Push 42, 60, 36 -> each released with note_lane=7, note_bad=1.
REQ-038 Push 10 notes with no beats elapsed -> fifo_count=8, overflow=1, first 8 released, last 2 lost.
REQ-039 Hold note_ready=0 over 3 beats with FIFO holding 2 notes -> note_valid stays, note_code stable, 3 miss pulses, fifo_count=2.
REQ-040 Empty FIFO across 2 beats -> 2 miss pulses, note_valid=0; then full push at beat cycle with count=DEPTH and note_ready=1 -> accepted, count stays 8, overflow=0.
REQ-041 Assert clear, then resetn low, while 4 notes queued and one held -> all outputs 0 immediately, next beat after release at cycle 4, no note emitted.

Source files
------------

// File: rtl/beat_note_scheduler.sv
// Beat-paced note scheduler: buffers incoming note codes in a FIFO and releases
// at most one note per beat into a valid/ready output register with lane decode.
module beat_note_scheduler #(
    parameter int BEAT_DIV = 12500000,
    parameter int DEPTH    = 8,
    parameter int BASE     = 40,
    parameter int STEP     = 4,
    parameter int LANES    = 5
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     clear,
    input  logic                     in_en,
    input  logic [7:0]               in_data,
    output logic                     note_valid,
    input  logic                     note_ready,
    output logic [7:0]               note_code,
    output logic [2:0]               note_lane,
    output logic                     note_bad,
    output logic                     beat,
    output logic                     miss,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int CW = $clog2(BEAT_DIV);
    localparam int PW = $clog2(DEPTH);
    localparam int FW = PW + 1;

    logic [CW-1:0] cnt_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [FW-1:0] count_reg;
    logic [FW-1:0] count_next;
    logic          overflow_reg;
    logic          note_valid_reg;
    logic [7:0]    note_code_reg;
    logic [2:0]    note_lane_reg;
    logic          note_bad_reg;

    logic [7:0]    mem [DEPTH];
    logic [7:0]    head_code;
    logic [2:0]    lane_next;
    logic          bad_next;
    logic [LANES-1:0] lane_hit;

    logic beat_cycle;
    logic full;
    logic empty;
    logic pop;
    logic push;
    logic drop;

    assign beat_cycle = (cnt_reg == CW'(BEAT_DIV - 1)) && !clear;
    assign full       = (count_reg == FW'(DEPTH));
    assign empty      = (count_reg == '0);
    // Pop decision uses pre-push occupancy, so a note entering an empty FIFO waits a beat.
    assign pop        = beat_cycle && !empty && (!note_valid_reg || note_ready);
    assign push       = in_en && !clear && (!full || pop);
    assign drop       = in_en && !clear && full && !pop;

    assign head_code  = mem[rd_ptr_reg];

    // Compare against each lane's grid code in full integer width so codes below BASE never wrap.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_hit[gi] = (32'(head_code) == BASE + gi * STEP);
        end
    endgenerate

    always_comb begin
        lane_next = 3'd7;
        bad_next  = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            if (lane_hit[i]) begin
                lane_next = 3'(i);
                bad_next  = 1'b0;
            end
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_reg        <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
            note_valid_reg <= 1'b0;
            note_code_reg  <= '0;
            note_lane_reg  <= '0;
            note_bad_reg   <= 1'b0;
        end else if (clear) begin
            cnt_reg        <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
            note_valid_reg <= 1'b0;
            note_code_reg  <= '0;
            note_lane_reg  <= '0;
            note_bad_reg   <= 1'b0;
        end else begin
            cnt_reg   <= beat_cycle ? '0 : cnt_reg + 1'b1;
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg     <= rd_ptr_reg + 1'b1;
                note_valid_reg <= 1'b1;
                note_code_reg  <= head_code;
                note_lane_reg  <= lane_next;
                note_bad_reg   <= bad_next;
            end else if (note_valid_reg && note_ready) begin
                note_valid_reg <= 1'b0;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign beat       = beat_cycle;
    assign miss       = beat_cycle && !pop;
    assign note_valid = note_valid_reg;
    assign note_code  = note_code_reg;
    assign note_lane  = note_lane_reg;
    assign note_bad   = note_bad_reg;
    assign fifo_count = count_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_beat_note_scheduler.sv
// Self-checking bench for beat_note_scheduler: queue-based reference model compared
// every cycle, directed scenarios pinned with literal expectations, then random traffic.
module tb_beat_note_scheduler;

    localparam int BD    = 4;
    localparam int DP    = 8;
    localparam int BASE  = 40;
    localparam int STEP  = 4;
    localparam int LANES = 5;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       clear = 1'b0;
    logic       in_en = 1'b0;
    logic [7:0] in_data = '0;
    logic       note_ready = 1'b0;
    logic       note_valid;
    logic [7:0] note_code;
    logic [2:0] note_lane;
    logic       note_bad;
    logic       beat;
    logic       miss;
    logic [3:0] fifo_count;
    logic       overflow;

    beat_note_scheduler #(
        .BEAT_DIV(BD), .DEPTH(DP), .BASE(BASE), .STEP(STEP), .LANES(LANES)
    ) dut (
        .clk(clk), .resetn(resetn), .clear(clear), .in_en(in_en), .in_data(in_data),
        .note_valid(note_valid), .note_ready(note_ready), .note_code(note_code),
        .note_lane(note_lane), .note_bad(note_bad), .beat(beat), .miss(miss),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int         phase = 0;
    logic [7:0] mq[$];
    bit         m_valid = 0;
    logic [7:0] m_code = 0;
    bit         m_ovf = 0;

    // Observations for literal checks
    int rel_code[$];
    int rel_lane[$];
    int rel_bad[$];
    int miss_seen = 0;
    int beat_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lane_of(input int c);
        if (c >= BASE && (c - BASE) % STEP == 0 && (c - BASE) / STEP < LANES)
            return (c - BASE) / STEP;
        return 7;
    endfunction

    task automatic model_flush();
        mq.delete();
        m_valid = 0;
        m_code  = 0;
        m_ovf   = 0;
        phase   = 0;
    endtask

    task automatic step(input bit en, input logic [7:0] d, input bit rdy, input bit clr);
        bit e_beat, e_pop, e_miss, drop;
        @(negedge clk);
        in_en = en; in_data = d; note_ready = rdy; clear = clr;
        #1;
        e_beat = !clr && (phase == BD - 1);
        e_pop  = e_beat && mq.size() > 0 && (!m_valid || rdy);
        e_miss = e_beat && !e_pop;
        chk("beat", int'(beat), int'(e_beat));
        chk("miss", int'(miss), int'(e_miss));
        chk("note_valid", int'(note_valid), int'(m_valid));
        chk("fifo_count", int'(fifo_count), mq.size());
        chk("overflow", int'(overflow), int'(m_ovf));
        if (m_valid) begin
            chk("note_code", int'(note_code), int'(m_code));
            chk("note_lane", int'(note_lane), lane_of(int'(m_code)));
            chk("note_bad", int'(note_bad), int'(lane_of(int'(m_code)) == 7));
        end
        if (note_valid && rdy && !clr) begin
            rel_code.push_back(int'(note_code));
            rel_lane.push_back(int'(note_lane));
            rel_bad.push_back(int'(note_bad));
        end
        if (miss) miss_seen++;
        if (beat) beat_seen++;
        @(posedge clk);
        if (clr) begin
            model_flush();
        end else begin
            drop = en && mq.size() == DP && !e_pop;
            if (e_pop) begin
                m_code  = mq.pop_front();
                m_valid = 1;
            end else if (m_valid && rdy) begin
                m_valid = 0;
            end
            if (en && !drop) mq.push_back(d);
            if (drop) m_ovf = 1;
            phase = (phase + 1) % BD;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, int'(note_valid), 0);
        chk({tag, "_code"}, int'(note_code), 0);
        chk({tag, "_lane"}, int'(note_lane), 0);
        chk({tag, "_bad"}, int'(note_bad), 0);
        chk({tag, "_beat"}, int'(beat), 0);
        chk({tag, "_miss"}, int'(miss), 0);
        chk({tag, "_count"}, int'(fifo_count), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
    endtask

    // Reset asserted mid-cycle, released shortly after a rising edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        in_en = 0; clear = 0; note_ready = 0;
        resetn = 0;
        #1;
        check_zero("rst");
        model_flush();
        repeat (2) @(posedge clk);
        #2;
        resetn = 1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 8'd0, rdy, 0);
    endtask

    task automatic wait_valid(input string name, input bit rdy);
        int g = 0;
        while (!m_valid && g < 20) begin
            step(0, 8'd0, rdy, 0);
            g++;
        end
        chk({name, "_timeout"}, int'(m_valid), 1);
    endtask

    initial begin
        int first_beat;
        int g;
        logic [7:0] d;

        repeat (3) @(posedge clk);
        #1;
        check_zero("init");
        @(posedge clk);
        #2;
        resetn = 1;

        // In-order grid notes, lanes 0..4
        rel_code.delete(); rel_lane.delete(); rel_bad.delete();
        for (int i = 0; i < 5; i++) step(1, 8'(40 + 4 * i), 1, 0);
        idle(30, 1);
        chk("grid_n", rel_code.size(), 5);
        for (int i = 0; i < 5 && i < rel_code.size(); i++) begin
            chk("grid_code", rel_code[i], 40 + 4 * i);
            chk("grid_lane", rel_lane[i], i);
            chk("grid_bad", rel_bad[i], 0);
        end

        // Off-grid, above range, below base
        rel_code.delete(); rel_lane.delete(); rel_bad.delete();
        step(1, 8'd42, 1, 0);
        step(1, 8'd60, 1, 0);
        step(1, 8'd36, 1, 0);
        idle(20, 1);
        chk("bad_n", rel_code.size(), 3);
        for (int i = 0; i < 3 && i < rel_code.size(); i++) begin
            chk("bad_lane", rel_lane[i], 7);
            chk("bad_flag", rel_bad[i], 1);
        end

        // Overflow: held note stalls the FIFO, then 10 pushes
        step(1, 8'd40, 0, 0);
        wait_valid("ovf_hold", 0);
        for (int i = 0; i < 10; i++) step(1, 8'(100 + i), 0, 0);
        #1;
        chk("ovf_count", int'(fifo_count), 8);
        chk("ovf_flag", int'(overflow), 1);
        rel_code.delete(); rel_lane.delete(); rel_bad.delete();
        idle(50, 1);
        chk("ovf_rel_n", rel_code.size(), 9);
        if (rel_code.size() == 9) begin
            chk("ovf_rel_first", rel_code[1], 100);
            chk("ovf_rel_last", rel_code[8], 107);
        end
        step(0, 8'd0, 1, 1);

        // Stalled consumer over 3 beats
        step(1, 8'd44, 0, 0);
        step(1, 8'd48, 0, 0);
        step(1, 8'd52, 0, 0);
        wait_valid("stall_hold", 0);
        miss_seen = 0;
        idle(12, 0);
        #1;
        chk("stall_miss", miss_seen, 3);
        chk("stall_count", int'(fifo_count), 2);
        chk("stall_code", int'(note_code), 44);
        idle(20, 1);

        // Empty FIFO across 2 beats
        miss_seen = 0;
        idle(8, 1);
        chk("empty_miss", miss_seen, 2);
        chk("empty_valid", int'(note_valid), 0);

        // Full FIFO with push on a beat that also pops
        step(0, 8'd0, 1, 1);
        g = 0;
        while (mq.size() < DP && g < 30) begin
            step(1, 8'(60 + g), 0, 0);
            g++;
        end
        g = 0;
        while (phase != BD - 1 && g < 8) begin
            step(0, 8'd0, 0, 0);
            g++;
        end
        step(1, 8'h77, 1, 0);
        #1;
        chk("fullbeat_count", int'(fifo_count), 8);
        chk("fullbeat_ovf", int'(overflow), 0);

        // Clear then reset with queued and held notes
        step(0, 8'd0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 8'(40 + 4 * i), 0, 0);
        wait_valid("rst_hold", 0);
        step(0, 8'd0, 0, 1);
        do_reset();
        first_beat = 0;
        beat_seen  = 0;
        for (int i = 1; i <= 10; i++) begin
            step(0, 8'd0, 1, 0);
            if (beat_seen > 0 && first_beat == 0) first_beat = i;
        end
        chk("rst_first_beat", first_beat, 4);
        chk("rst_no_note", int'(note_valid), 0);

        // Random traffic including occasional clears and one mid-run reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) d = 8'(BASE + STEP * $urandom_range(0, 6));
            else d = 8'($urandom_range(0, 255));
            if (i == 1500) do_reset();
            step($urandom_range(0, 99) < 45, d, $urandom_range(0, 99) < 60,
                 $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
